timer_cuenta_regresiva: RTL and testbench
=========================================

// Module: timer_cuenta_regresiva
// PURPOSE
//  Countdown timer for the RTC display: holds hh:mm:ss in packed BCD, decrements on a
//  1 Hz tick and raises activar_alarma on expiry. Sits directly upstream of VGATOP:
//  timer_hh/mm/ss feed timer_in1/2/3 and activar_alarma feeds the RING overlay.
// PARAMETERS
//  MAX_HOURS     23   highest legal hours value on load (binary, compared after BCD decode)
//  RING_SECONDS  10   tick count after which an unacknowledged alarm self-clears (1..255)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-low reset
//  tick_1hz        in   1  one-clk-wide pulse, once per second
//  load            in   1  one-clk pulse: capture load_hh/mm/ss
//  load_hh         in   8  BCD hours   {tens,units}
//  load_mm         in   8  BCD minutes {tens,units}
//  load_ss         in   8  BCD seconds {tens,units}
//  start           in   1  one-clk pulse: begin/resume counting
//  stop            in   1  one-clk pulse: pause counting
//  ack_alarma      in   1  one-clk pulse: silence alarm
//  timer_hh        out  8  current BCD hours
//  timer_mm        out  8  current BCD minutes
//  timer_ss        out  8  current BCD seconds
//  activar_alarma  out  1  high while in RING
//  running         out  1  high while in RUN
//  load_err        out  1  one-clk pulse: rejected load
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; timer_hh/mm/ss=8'h00; reload copy=00:00:00;
//    activar_alarma=0; running=0; load_err=0; ring counter=0.
//  - All outputs registered; every update visible the clk after the causing input.
//  - FSM states IDLE, RUN, PAUSE, RING:
//    IDLE : load applies; start with value!=0 -> RUN; start with value==0 -> stay IDLE.
//    RUN  : tick -> decrement 1 s; stop -> PAUSE; load ignored (no load_err).
//           decrement reaching 00:00:00 -> RING in the same update (alarm 1 clk after tick).
//    PAUSE: load applies; start -> RUN (value!=0) else IDLE; tick ignored.
//    RING : activar_alarma=1; ack_alarma -> exit; else count ticks, at RING_SECONDS -> exit.
//           load/start/stop ignored in RING.
//  - Decrement: BCD with borrow; ss 00->59 borrows mm, mm 00->59 borrows hh; no wrap below 0.
//  - Load validation: every nibble<=9, mm/ss tens<=5, hh decoded<=MAX_HOURS. Invalid ->
//    value unchanged, load_err=1 for one clk. Valid -> value and reload copy updated.
//  - Priority within one clk: load > start > stop > tick. stop+tick in RUN: no decrement,
//    go PAUSE. load+start in IDLE: load applied, start ignored. ack outside RING ignored.
//  - Reset asserted mid-count or mid-ring: immediate return to reset values.
// CONFIGURATION
//  TIMER_AUTORELOAD_EN defined: RING exit reloads value from reload copy and enters RUN
//    (if reload copy==0 -> IDLE). running=0 during RING.
//  Not defined: RING exit -> IDLE with value 00:00:00.
// TESTING
//  1 reset=0 mid-run -> all outputs 0, state IDLE; release, tick -> outputs stay 0.
//  2 load 00:01:00, start, 1 tick -> 00:00:59 (borrow); 59 more ticks -> 00:00:00,
//    activar_alarma=1 one clk after 60th tick, running=0.
//  3 load 00:00:02, start, expire; ack_alarma -> activar_alarma=0 next clk, IDLE; and
//    repeat without ack -> alarm clears exactly on 10th tick (RING_SECONDS=10).
//  4 load_hh=8'h24, or load_mm=8'h60, or load_ss=8'h0A -> load_err pulse, value unchanged.
//  5 RUN at 01:00:00: stop+tick same clk -> 01:00:00, PAUSE; start -> RUN; tick -> 00:59:59.
//  6 TIMER_AUTORELOAD_EN, load 00:00:03, start, expire, ack -> 00:00:03, running=1.

Source files
------------

// File: rtl/timer_cuenta_regresiva_if.sv
// Control/data bundle between the RTC control logic (master) and the countdown timer (slave).
interface timer_cuenta_regresiva_if;
    logic       tick_1hz;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       start;
    logic       stop;
    logic       ack_alarma;
    logic [7:0] timer_hh;
    logic [7:0] timer_mm;
    logic [7:0] timer_ss;
    logic       activar_alarma;
    logic       running;
    logic       load_err;

    modport master (
        output tick_1hz, load, load_hh, load_mm, load_ss, start, stop, ack_alarma,
        input  timer_hh, timer_mm, timer_ss, activar_alarma, running, load_err
    );

    modport slave (
        input  tick_1hz, load, load_hh, load_mm, load_ss, start, stop, ack_alarma,
        output timer_hh, timer_mm, timer_ss, activar_alarma, running, load_err
    );
endinterface

// File: rtl/timer_cuenta_regresiva.sv
// BCD hh:mm:ss countdown timer with alarm ring for the RTC display.
// Define TIMER_AUTORELOAD_EN to reload the last loaded value and keep running after the ring.
module timer_cuenta_regresiva #(
    parameter int unsigned MAX_HOURS    = 23,
    parameter int unsigned RING_SECONDS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    timer_cuenta_regresiva_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StRing} state_e;

    localparam logic [7:0] RingLast = 8'(RING_SECONDS - 1);

    state_e      state_q, state_d;
    logic [23:0] value_q, value_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic        load_err_q, load_err_d;
    logic        alarm_q;
    logic        running_q;

    logic [23:0] load_value;
    logic [23:0] dec_value;
    logic        load_ok;

    function automatic logic [23:0] dec_time(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (t != 24'h0) begin
            if (s0 != 4'd0) begin
                s0 = s0 - 4'd1;
            end else if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
                s0 = 4'd9;
            end else begin
                s1 = 4'd5;
                s0 = 4'd9;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                    m0 = 4'd9;
                end else begin
                    m1 = 4'd5;
                    m0 = 4'd9;
                    // Non-zero value with mm:ss at zero guarantees hours are non-zero here.
                    if (h0 != 4'd0) begin
                        h0 = h0 - 4'd1;
                    end else if (h1 != 4'd0) begin
                        h1 = h1 - 4'd1;
                        h0 = 4'd9;
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    function automatic logic valid_time(input logic [23:0] t);
        logic [3:0]  h1, h0, m1, m0, s1, s0;
        int unsigned hrs;
        {h1, h0, m1, m0, s1, s0} = t;
        hrs = 32'(h1) * 32'd10 + 32'(h0);
        return (h1 <= 4'd9) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
               (s1 <= 4'd5) && (s0 <= 4'd9) && (hrs <= MAX_HOURS);
    endfunction

    assign load_value = {bus.load_hh, bus.load_mm, bus.load_ss};
    assign load_ok    = valid_time(load_value);
    assign dec_value  = dec_time(value_q);

`ifdef TIMER_AUTORELOAD_EN
    // Last accepted load; only needed when the ring hands back to a fresh countdown.
    logic [23:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        ring_cnt_d = ring_cnt_q;
        load_err_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        reload_d   = reload_q;
`endif

        unique case (state_q)
            StIdle, StPause: begin
                if (bus.load) begin
                    if (load_ok) begin
                        value_d = load_value;
`ifdef TIMER_AUTORELOAD_EN
                        reload_d = load_value;
`endif
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (bus.start) begin
                    state_d = (value_q != 24'h0) ? StRun : StIdle;
                end
            end

            StRun: begin
                // A start while already running is a no-op but still outranks stop/tick.
                if (!bus.start) begin
                    if (bus.stop) begin
                        state_d = StPause;
                    end else if (bus.tick_1hz) begin
                        value_d = dec_value;
                        if (dec_value == 24'h0) begin
                            state_d    = StRing;
                            ring_cnt_d = 8'd0;
                        end
                    end
                end
            end

            StRing: begin
                if (bus.ack_alarma || (bus.tick_1hz && ring_cnt_q == RingLast)) begin
                    ring_cnt_d = 8'd0;
`ifdef TIMER_AUTORELOAD_EN
                    value_d = reload_q;
                    state_d = (reload_q != 24'h0) ? StRun : StIdle;
`else
                    value_d = 24'h0;
                    state_d = StIdle;
`endif
                end else if (bus.tick_1hz) begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            value_q    <= 24'h0;
            ring_cnt_q <= 8'd0;
            load_err_q <= 1'b0;
            alarm_q    <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            ring_cnt_q <= ring_cnt_d;
            load_err_q <= load_err_d;
            alarm_q    <= (state_d == StRing);
            running_q  <= (state_d == StRun);
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= 24'h0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign bus.timer_hh       = value_q[23:16];
    assign bus.timer_mm       = value_q[15:8];
    assign bus.timer_ss       = value_q[7:0];
    assign bus.activar_alarma = alarm_q;
    assign bus.running        = running_q;
    assign bus.load_err       = load_err_q;

endmodule

// File: tb/tb_timer_cuenta_regresiva.sv
// Directed-vector bench for timer_cuenta_regresiva; expectations are hand-computed BCD values.
module tb_timer_cuenta_regresiva;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    timer_cuenta_regresiva_if bus ();

    timer_cuenta_regresiva #(
        .MAX_HOURS   (23),
        .RING_SECONDS(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] cur_time();
        return {bus.timer_hh, bus.timer_mm, bus.timer_ss};
    endfunction

    // Drive one clock's worth of pulses; outputs are sampled 1 ns after the capturing edge.
    task automatic apply(input bit ld, input bit st, input bit sp, input bit tk, input bit ak);
        @(negedge clk);
        bus.load       = ld;
        bus.start      = st;
        bus.stop       = sp;
        bus.tick_1hz   = tk;
        bus.ack_alarma = ak;
        @(posedge clk);
        #1;
        bus.load       = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.tick_1hz   = 1'b0;
        bus.ack_alarma = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] v);
        {bus.load_hh, bus.load_mm, bus.load_ss} = v;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        bus.load       = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.tick_1hz   = 1'b0;
        bus.ack_alarma = 1'b0;
        bus.load_hh    = 8'h00;
        bus.load_mm    = 8'h00;
        bus.load_ss    = 8'h00;

        // Reset state
        #12;
        check_eq("rst_time", 32'(cur_time()), 32'h000000);
        check_eq("rst_alarm", 32'(bus.activar_alarma), 32'd0);
        check_eq("rst_running", 32'(bus.running), 32'd0);
        check_eq("rst_load_err", 32'(bus.load_err), 32'd0);
        reset = 1'b1;

        // Start with zero value stays idle
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("start_zero_running", 32'(bus.running), 32'd0);

        // Reset mid-run
        do_load(24'h000010);
        check_eq("t1_loaded", 32'(cur_time()), 32'h000010);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("t1_running", 32'(bus.running), 32'd1);
        do_ticks(1);
        check_eq("t1_tick", 32'(cur_time()), 32'h000009);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t1_async_time", 32'(cur_time()), 32'h000000);
        check_eq("t1_async_running", 32'(bus.running), 32'd0);
        #1;
        reset = 1'b1;
        do_ticks(1);
        check_eq("t1_after_tick_time", 32'(cur_time()), 32'h000000);
        check_eq("t1_after_tick_run", 32'(bus.running), 32'd0);

        // Borrow across minutes, then expiry on the 60th tick
        do_reset();
        do_load(24'h000100);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        do_ticks(1);
        check_eq("t2_borrow", 32'(cur_time()), 32'h000059);
        do_ticks(58);
        check_eq("t2_one_left", 32'(cur_time()), 32'h000001);
        check_eq("t2_no_alarm_yet", 32'(bus.activar_alarma), 32'd0);
        do_ticks(1);
        check_eq("t2_zero", 32'(cur_time()), 32'h000000);
        check_eq("t2_alarm", 32'(bus.activar_alarma), 32'd1);
        check_eq("t2_running", 32'(bus.running), 32'd0);

        // Ack exits ring; ring ignores start
        do_reset();
        do_load(24'h000002);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        do_ticks(2);
        check_eq("t3_alarm", 32'(bus.activar_alarma), 32'd1);
        apply(1'b0, 1'b1, 1'b1, 0, 0);
        check_eq("t3_ring_ignores_start", 32'(bus.activar_alarma), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check_eq("t3_ack_alarm", 32'(bus.activar_alarma), 32'd0);
`ifdef TIMER_AUTORELOAD_EN
        check_eq("t3_ack_time", 32'(cur_time()), 32'h000002);
        check_eq("t3_ack_running", 32'(bus.running), 32'd1);
`else
        check_eq("t3_ack_time", 32'(cur_time()), 32'h000000);
        check_eq("t3_ack_running", 32'(bus.running), 32'd0);
`endif

        // Unacknowledged ring clears on the 10th tick
        do_reset();
        do_load(24'h000002);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        do_ticks(2);
        do_ticks(9);
        check_eq("t3_ring_9_ticks", 32'(bus.activar_alarma), 32'd1);
        do_ticks(1);
        check_eq("t3_ring_10_ticks", 32'(bus.activar_alarma), 32'd0);
`ifdef TIMER_AUTORELOAD_EN
        check_eq("t3_timeout_running", 32'(bus.running), 32'd1);
`else
        check_eq("t3_timeout_running", 32'(bus.running), 32'd0);
`endif

        // Load validation
        do_reset();
        do_load(24'h010203);
        check_eq("t4_valid", 32'(cur_time()), 32'h010203);
        check_eq("t4_valid_err", 32'(bus.load_err), 32'd0);
        do_load(24'h240000);
        check_eq("t4_hh24_err", 32'(bus.load_err), 32'd1);
        check_eq("t4_hh24_time", 32'(cur_time()), 32'h010203);
        apply(0, 0, 0, 0, 0);
        check_eq("t4_err_pulse", 32'(bus.load_err), 32'd0);
        do_load(24'h006000);
        check_eq("t4_mm60_err", 32'(bus.load_err), 32'd1);
        check_eq("t4_mm60_time", 32'(cur_time()), 32'h010203);
        do_load(24'h00000A);
        check_eq("t4_ss0a_err", 32'(bus.load_err), 32'd1);
        check_eq("t4_ss0a_time", 32'(cur_time()), 32'h010203);
        do_load(24'h235959);
        check_eq("t4_max_valid", 32'(cur_time()), 32'h235959);
        check_eq("t4_max_err", 32'(bus.load_err), 32'd0);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        do_ticks(1);
        check_eq("t4_max_dec", 32'(cur_time()), 32'h235958);
        do_load(24'h050000);
        check_eq("t4_run_load_time", 32'(cur_time()), 32'h235958);
        check_eq("t4_run_load_err", 32'(bus.load_err), 32'd0);

        // stop+tick in the same clock pauses without decrementing
        do_reset();
        do_load(24'h010000);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 0);
        check_eq("t5_stop_tick_time", 32'(cur_time()), 32'h010000);
        check_eq("t5_paused", 32'(bus.running), 32'd0);
        do_ticks(1);
        check_eq("t5_pause_tick", 32'(cur_time()), 32'h010000);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("t5_resume", 32'(bus.running), 32'd1);
        do_ticks(1);
        check_eq("t5_hour_borrow", 32'(cur_time()), 32'h005959);

`ifdef TIMER_AUTORELOAD_EN
        // Autoreload after ack
        do_reset();
        do_load(24'h000003);
        apply(1'b0, 1'b1, 1'b0, 0, 0);
        do_ticks(3);
        check_eq("t6_alarm", 32'(bus.activar_alarma), 32'd1);
        check_eq("t6_ring_running", 32'(bus.running), 32'd0);
        apply(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check_eq("t6_reload_time", 32'(cur_time()), 32'h000003);
        check_eq("t6_reload_running", 32'(bus.running), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
